// File: rtl/uart_tx_feeder_if.sv
// Host write / transmitter handshake bundle for uart_tx_feeder.
// master = environment (host + transmitter), slave = the feeder itself.
interface uart_tx_feeder_if #(
  parameter int data_width = 8,
  parameter int addr_width = 4
);
  logic                  wr_en;
  logic [data_width-1:0] wr_data;
  logic                  pause;
  logic                  ovf_clr;
  logic                  full;
  logic                  empty;
  logic [addr_width:0]   count;
  logic                  overflow;
  logic                  tx_en;
  logic [data_width-1:0] tx_data;
  logic                  tx_done;
  logic                  tx_timeout;

  modport master (
    output wr_en, wr_data, pause, ovf_clr, tx_done,
    input  full, empty, count, overflow, tx_en, tx_data, tx_timeout
  );

  modport slave (
    input  wr_en, wr_data, pause, ovf_clr, tx_done,
    output full, empty, count, overflow, tx_en, tx_data, tx_timeout
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter over a tx_en/tx_data/tx_done handshake,
// with inter-frame gap, stall timeout and sticky overflow reporting.
module uart_tx_feeder #(
  parameter int data_width     = 8,
  parameter int fifo_depth     = 16,
  parameter int addr_width     = 4,
  parameter int timeout_cycles = 2_000_000,
  parameter int gap_cycles     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_feeder_if.slave  bus
);

  localparam int TW = $clog2(timeout_cycles);
  localparam int GW = (gap_cycles > 1) ? $clog2(gap_cycles) : 1;
  localparam logic [TW-1:0]       TLAST = TW'(timeout_cycles - 1);
  localparam logic [GW-1:0]       GLAST = GW'((gap_cycles > 0) ? gap_cycles - 1 : 0);
  localparam logic [addr_width:0] DEPTH = (addr_width + 1)'(fifo_depth);

  typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} state_t;

  state_t state, state_nxt;

  logic [data_width-1:0] mem [fifo_depth];
  logic [addr_width-1:0] wr_ptr, rd_ptr;
  logic [addr_width:0]   count_r, count_nxt;
  logic                  full_r, empty_r, ovf_r, tmo_r;
  logic [data_width-1:0] data_r;
  logic [TW-1:0]         timer;
  logic [GW-1:0]         gap_cnt;
  logic                  pop, wr_ok, tmo_hit, tx_en_c;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (!empty_r && !bus.pause) state_nxt = WAIT_DONE;
      WAIT_DONE: if (bus.tx_done || timer == TLAST)
                   state_nxt = (gap_cycles > 0) ? GAP : IDLE;
      GAP:       if (gap_cnt == GLAST) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // state-decoded outputs and strobes
  always_comb begin
    pop     = (state == IDLE) && !empty_r && !bus.pause;
    tmo_hit = (state == WAIT_DONE) && !bus.tx_done && (timer == TLAST);
    tx_en_c = (state == WAIT_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer   <= '0;
      gap_cnt <= '0;
    end else begin
      if (pop)                     timer <= '0;
      else if (state == WAIT_DONE) timer <= timer + 1'b1;
      if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
      else              gap_cnt <= '0;
    end
  end

  // A full FIFO rejects a write even when a pop frees a slot this cycle.
  always_comb begin
    wr_ok     = bus.wr_en && !full_r;
    count_nxt = count_r;
    if (wr_ok && !pop)      count_nxt = count_r + 1'b1;
    else if (!wr_ok && pop) count_nxt = count_r - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      ovf_r   <= 1'b0;
      tmo_r   <= 1'b0;
      data_r  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        data_r <= mem[rd_ptr];
      end
      count_r <= count_nxt;
      full_r  <= (count_nxt == DEPTH);
      empty_r <= (count_nxt == '0);
      if (bus.wr_en && full_r) ovf_r <= 1'b1;
      else if (bus.ovf_clr)    ovf_r <= 1'b0;
      tmo_r <= tmo_hit;
    end
  end

  assign bus.full       = full_r;
  assign bus.empty      = empty_r;
  assign bus.count      = count_r;
  assign bus.overflow   = ovf_r;
  assign bus.tx_en      = tx_en_c;
  assign bus.tx_data    = data_r;
  assign bus.tx_timeout = tmo_r;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Two feeders (gap 0 and gap 5) share host stimulus; each has its own
// transmitter responder and a queue-based reference model.
module tb_uart_tx_feeder;

  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, pause, ovf_clr, force_done, spur_en, reply_never;
  logic [7:0] wr_data;
  int         reply_lo, reply_hi;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  task automatic check(input int inst, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s: got %0h expected %0h at %0t", inst, name, act, exp, $time);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int G = (k == 0) ? 0 : 5;

    uart_tx_feeder_if #(.data_width(8), .addr_width(4)) bus ();

    uart_tx_feeder #(
      .data_width(8), .fifo_depth(16), .addr_width(4),
      .timeout_cycles(TMO), .gap_cycles(G)
    ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    logic        done_r = 1'b0;
    logic        armed  = 1'b0;
    int unsigned wait_left;

    assign bus.wr_en   = wr_en;
    assign bus.wr_data = wr_data;
    assign bus.pause   = pause;
    assign bus.ovf_clr = ovf_clr;
    assign bus.tx_done = done_r | force_done;

    // transmitter: answer each request after a random delay (or never)
    always @(negedge clk) begin
      done_r = 1'b0;
      if (bus.tx_en) begin
        if (!armed) begin
          armed     = 1'b1;
          wait_left = reply_never ? 32'hFFFF_FFFF
                                  : $urandom_range(reply_hi, reply_lo);
        end
        if (wait_left == 0) done_r = 1'b1;
        else                wait_left--;
      end else begin
        armed  = 1'b0;
        done_r = spur_en && ($urandom_range(0, 15) == 0);
      end
    end

    // reference model: byte queue plus edge-count bookkeeping
    logic [7:0]  q[$];
    int unsigned cyc = 0;
    int unsigned launched, idle_from;
    bit          mvalid = 0, inflight, e_ovf, e_tmo;
    logic [7:0]  e_data;

    always @(posedge clk) begin
      int sz;
      if (!rst_n) begin
        q.delete();
        inflight  = 0;
        idle_from = 0;
        e_data    = '0;
        e_ovf     = 0;
        e_tmo     = 0;
        mvalid    = 1;
      end else if (mvalid) begin
        sz    = q.size();
        e_tmo = 0;
        if (inflight) begin
          if (bus.tx_done) begin
            inflight  = 0;
            idle_from = cyc + G + 1;
          end else if (cyc - launched == TMO) begin
            inflight  = 0;
            e_tmo     = 1;
            idle_from = cyc + G + 1;
          end
        end else if (cyc >= idle_from && sz > 0 && !pause) begin
          e_data   = q.pop_front();
          inflight = 1;
          launched = cyc;
        end
        if (wr_en) begin
          if (sz == 16) e_ovf = 1;
          else          q.push_back(wr_data);
        end
        if (!(wr_en && sz == 16) && ovf_clr) e_ovf = 0;
      end
      cyc++;
    end

    always @(negedge clk) begin
      if (mvalid) begin
        check(k, "tx_en",      bus.tx_en,      inflight);
        check(k, "tx_data",    bus.tx_data,    e_data);
        check(k, "tx_timeout", bus.tx_timeout, e_tmo);
        check(k, "count",      bus.count,      q.size());
        check(k, "empty",      bus.empty,      q.size() == 0);
        check(k, "full",       bus.full,       q.size() == 16);
        check(k, "overflow",   bus.overflow,   e_ovf);
      end
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic wait_rise0(input string name, output int ok);
    int n = 0;
    while (!g_dut[0].bus.tx_en && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = g_dut[0].bus.tx_en;
    check(0, name, ok, 1);
  endtask

  initial begin
    int         n, ok;
    int         got[2];
    int         low_run[2];
    logic [1:0] en_now, en_prev;
    logic [7:0] d_now[2];
    int         wprob[4];
    int         rlo[4];
    int         rhi[4];

    rst_n = 0; wr_en = 0; wr_data = '0; pause = 0; ovf_clr = 0;
    force_done = 0; spur_en = 0; reply_never = 0; reply_lo = 50; reply_hi = 50;
    repeat (3) @(negedge clk);
    check(0, "rst_tx_en",   g_dut[0].bus.tx_en,   0);
    check(0, "rst_tx_data", g_dut[0].bus.tx_data, 0);
    check(0, "rst_count",   g_dut[0].bus.count,   0);
    check(0, "rst_empty",   g_dut[0].bus.empty,   1);
    rst_n = 1;
    @(negedge clk);

    // single byte, answered 50 cycles after the request
    wr_en = 1; wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 0;
    check(0, "a5_not_yet", g_dut[0].bus.tx_en, 0);
    @(negedge clk);
    check(0, "a5_tx_en",   g_dut[0].bus.tx_en,   1);
    check(0, "a5_tx_data", g_dut[0].bus.tx_data, 8'hA5);
    n = 0;
    while (g_dut[0].bus.tx_en && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(0, "a5_high_cycles", n, 51);
    check(0, "a5_empty", g_dut[0].bus.empty, 1);
    check(0, "a5_count", g_dut[0].bus.count, 0);

    // fill while paused, then overflow
    pause = 1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; wr_data = 8'(i);
      @(negedge clk);
    end
    wr_data = 8'hFF;
    @(negedge clk);
    wr_en = 0;
    for (int k = 0; k < 2; k++) begin
      check(k, "fill_full",  (k == 0) ? g_dut[0].bus.full     : g_dut[1].bus.full,     1);
      check(k, "fill_count", (k == 0) ? g_dut[0].bus.count    : g_dut[1].bus.count,    16);
      check(k, "fill_ovf",   (k == 0) ? g_dut[0].bus.overflow : g_dut[1].bus.overflow, 1);
    end
    ovf_clr = 1;
    @(negedge clk);
    ovf_clr = 0;
    check(0, "ovf_cleared", g_dut[0].bus.overflow, 0);

    // drain: bytes in order, fixed idle spacing between requests
    reply_lo = 10; reply_hi = 10;
    pause = 0;
    got = '{0, 0}; low_run = '{0, 0}; en_prev = '0;
    n = 0;
    while ((got[0] < 16 || got[1] < 16) && n < 1000) begin
      @(negedge clk);
      n++;
      en_now   = {g_dut[1].bus.tx_en, g_dut[0].bus.tx_en};
      d_now[0] = g_dut[0].bus.tx_data;
      d_now[1] = g_dut[1].bus.tx_data;
      for (int k = 0; k < 2; k++) begin
        if (en_now[k] && !en_prev[k]) begin
          if (got[k] > 0) check(k, "inter_byte_low", low_run[k], (k == 0) ? 1 : 6);
          check(k, "drain_order", d_now[k], got[k]);
          got[k]++;
        end
        low_run[k] = en_now[k] ? 0 : low_run[k] + 1;
      end
      en_prev = en_now;
    end
    check(0, "drain_bytes", got[0], 16);
    check(1, "drain_bytes", got[1], 16);
    repeat (40) @(negedge clk);

    // timeout on an unanswered byte, then normal launch of the next
    reply_never = 1;
    wr_en = 1; wr_data = 8'h3C;
    @(negedge clk);
    wr_en = 0;
    wait_rise0("tmo_launch", ok);
    n = 0;
    while (!g_dut[0].bus.tx_timeout && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(0, "tmo_latency", n, TMO);
    check(0, "tmo_tx_en", g_dut[0].bus.tx_en, 0);
    @(negedge clk);
    check(0, "tmo_one_pulse", g_dut[0].bus.tx_timeout, 0);
    reply_never = 0; reply_lo = 5; reply_hi = 20;
    wr_en = 1; wr_data = 8'h3D;
    @(negedge clk);
    wr_en = 0;
    wait_rise0("next_launch", ok);
    check(0, "next_data", g_dut[0].bus.tx_data, 8'h3D);
    repeat (60) @(negedge clk);

    // randomized traffic: timeout boundary, full FIFO, spurious done pulses
    wprob = '{30, 60, 90, 45};
    rlo   = '{0, 95, 0, 0};
    rhi   = '{12, 101, 4, 100};
    spur_en = 1;
    for (int p = 0; p < 4; p++) begin
      reply_lo = rlo[p]; reply_hi = rhi[p];
      for (int c = 0; c < 800; c++) begin
        wr_en   = ($urandom_range(0, 99) < wprob[p]);
        wr_data = 8'($urandom);
        pause   = ($urandom_range(0, 19) == 0);
        ovf_clr = ($urandom_range(0, 29) == 0);
        @(negedge clk);
      end
    end
    spur_en = 0; wr_en = 0; pause = 0; ovf_clr = 0;

    // clean reset, then reset while a byte is in flight with 3 queued
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    reply_never = 1;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_data = 8'(8'h50 + i);
      @(negedge clk);
    end
    wr_en = 0;
    wait_rise0("rst_inflight", ok);
    check(0, "rst_queued", g_dut[0].bus.count, 3);
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 2; k++) begin
      check(k, "mid_rst_tx_en", (k == 0) ? g_dut[0].bus.tx_en : g_dut[1].bus.tx_en, 0);
      check(k, "mid_rst_count", (k == 0) ? g_dut[0].bus.count : g_dut[1].bus.count, 0);
      check(k, "mid_rst_empty", (k == 0) ? g_dut[0].bus.empty : g_dut[1].bus.empty, 1);
    end
    force_done = 1;
    @(negedge clk);
    force_done = 0;
    repeat (3) @(negedge clk);
    check(0, "late_done_tx_en", g_dut[0].bus.tx_en,      0);
    check(0, "late_done_tmo",   g_dut[0].bus.tx_timeout, 0);
    check(0, "late_done_count", g_dut[0].bus.count,      0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Buffering stage directly upstream of the UART transmitter.
- Accepts bytes from a host write interface into a synchronous FIFO.
- Presents bytes one at a time to the transmitter using the tx_en / tx_data / tx_done handshake.
- Adds a configurable inter-frame gap, a stall timeout, and overflow reporting, so the host never has to track transmitter busy state.

Parameters:
- data_width, 8, width of each byte/word, matches the transmitter data width.
- fifo_depth, 16, FIFO entries; must be a power of 2.
- addr_width, 4, log2(fifo_depth).
- timeout_cycles, 2_000_000, clk cycles to wait for tx_done before abandoning a byte; must be ≥ 2.
- gap_cycles, 0, idle clk cycles inserted after each completed or abandoned byte.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- wr_en  input  1  host write strobe, one byte per cycle.
- wr_data  input  data_width  host byte.
- pause  input  1  when high, no new byte is launched; an in-flight byte completes.
- ovf_clr  input  1  clears the overflow flag.
- full  output  1  FIFO holds fifo_depth entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  addr_width+1  current FIFO occupancy.
- overflow  output  1  sticky; a write was dropped.
- tx_en  output  1  level request to the transmitter.
- tx_data  output  data_width  byte presented to the transmitter.
- tx_done  input  1  single-cycle pulse in the clk domain; the transmitter finished the frame.
- tx_timeout  output  1  single-cycle pulse; a byte was abandoned.

Behaviour:
- Reset (rst_n low at a clk edge):
  - rd/wr pointers = 0, count = 0, empty = 1, full = 0.
  - overflow = 0, tx_en = 0, tx_data = 0, tx_timeout = 0.
  - FSM goes to IDLE; timer and gap counter = 0.
  - Any in-flight byte is discarded.
- FIFO:
  - Write accepted when wr_en=1 and full=0; the data is stored at the edge.
  - wr_en=1 while full=1 drops the byte and sets overflow at the same edge.
  - full/empty/count are registered and reflect the state after the last edge.
  - A write and a pop in the same cycle both occur; count is unchanged.
  - A write while full is rejected even if a pop occurs in the same cycle.
  - Pointers wrap modulo fifo_depth; count has range 0..fifo_depth.
- Overflow flag:
  - ovf_clr=1 clears overflow.
  - A simultaneous dropped write takes priority: overflow = 1.
- FSM states: IDLE, WAIT_DONE, GAP.
- IDLE:
  - If empty=0 and pause=0: pop the head into tx_data, set tx_en=1, clear the timer, and go to WAIT_DONE at the same edge.
  - Latency: a byte written at edge N into an empty FIFO (pause=0) appears on tx_data with tx_en=1 after edge N+1.
- WAIT_DONE:
  - tx_en is held 1 and tx_data is held stable; wr activity does not disturb them. pause is ignored.
  - Timer increments each cycle.
  - tx_done=1: tx_en goes to 0 at that edge; go to GAP if gap_cycles>0, else IDLE.
  - Timer reaches timeout_cycles-1 with tx_done=0: tx_en goes to 0, tx_timeout pulses for 1 cycle, the byte is discarded (not retried), then go to GAP/IDLE as above.
  - tx_done arriving in the same cycle as the timeout limit counts as success: no tx_timeout.
- tx_done outside WAIT_DONE is ignored.
- GAP:
  - Gap counter runs gap_cycles cycles with tx_en=0, then goes to IDLE.
  - Back-to-back throughput with gap_cycles=0: tx_en is low for exactly 1 cycle between bytes (the IDLE cycle).
- tx_data keeps its last value while tx_en=0.

Test Plan:
- Reset, then write 0xA5 with pause=0:
  - tx_en rises one cycle after the write with tx_data=0xA5.
  - Pulse tx_done 50 cycles later: tx_en falls next edge; empty=1, count=0.
- Write 16 bytes 0x00..0x0F with pause=1, then a 17th write of 0xFF:
  - full=1, count=16, overflow=1, 0xFF is dropped.
  - Pulse ovf_clr: overflow=0.
- From that full FIFO, release pause and answer each tx_en with tx_done after 10 cycles:
  - Transmitter receives 0x00..0x0F in order.
  - tx_en is low exactly 1 cycle between bytes (gap_cycles=0).
- timeout_cycles=100; write 0x3C and never assert tx_done:
  - tx_timeout pulses once 100 cycles after tx_en rose; tx_en=0.
  - A following byte 0x3D is launched normally.
- gap_cycles=5; two bytes, tx_done acknowledged: tx_en stays low 6 cycles between bytes.
- rst_n low during WAIT_DONE with 3 bytes queued: next cycle tx_en=0, count=0, empty=1; a late tx_done pulse is ignored.
